// File: rtl/ceespu_pkg.sv
// Shared ceespu datapath constants.
// Register file geometry and result width used by the writeback stage.
package ceespu_pkg;
  localparam int CEESPU_DATA_W = 32;
  localparam int CEESPU_REG_AW = 5;
  localparam int CEESPU_NREGS  = 1 << CEESPU_REG_AW;
endpackage

// File: rtl/ceespu_writeback_if.sv
// Decode, ALU-result, load-result and regfile-write signals of the writeback stage.
// slave = writeback block, master = surrounding pipeline.
interface ceespu_writeback_if
  import ceespu_pkg::*;
#(
  parameter int DATA_W = CEESPU_DATA_W,
  parameter int REG_AW = CEESPU_REG_AW
);
  logic              I_dec_valid;
  logic              I_dec_we;
  logic              I_dec_is_load;
  logic [REG_AW-1:0] I_dec_rd;
  logic [REG_AW-1:0] I_selA;
  logic [REG_AW-1:0] I_selB;
  logic              O_stall;
  logic              I_alu_valid;
  logic [REG_AW-1:0] I_alu_rd;
  logic [DATA_W-1:0] I_alu_data;
  logic              I_ld_valid;
  logic [REG_AW-1:0] I_ld_rd;
  logic [DATA_W-1:0] I_ld_data;
  logic              O_ld_ready;
  logic              O_we;
  logic [REG_AW-1:0] O_selD;
  logic [DATA_W-1:0] O_dataD;
  logic              O_err;

  modport slave (
    input  I_dec_valid, I_dec_we, I_dec_is_load, I_dec_rd, I_selA, I_selB,
    input  I_alu_valid, I_alu_rd, I_alu_data,
    input  I_ld_valid, I_ld_rd, I_ld_data,
    output O_stall, O_ld_ready, O_we, O_selD, O_dataD, O_err
  );

  modport master (
    output I_dec_valid, I_dec_we, I_dec_is_load, I_dec_rd, I_selA, I_selB,
    output I_alu_valid, I_alu_rd, I_alu_data,
    output I_ld_valid, I_ld_rd, I_ld_data,
    input  O_stall, O_ld_ready, O_we, O_selD, O_dataD, O_err
  );
endinterface

// File: rtl/ceespu_wb_fifo.sv
// Small load-result queue; head is visible combinationally, pointers wrap by mask.
// Caller must not write when full nor read when empty.
module ceespu_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] MASK = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [PW:0]      count;

  assign full  = (count == (PW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rdPtr];

  // Storage needs no reset: count gates every read.
  always_ff @(posedge I_clk) begin
    if (wr_en) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wrPtr <= (wrPtr + 1'b1) & MASK;
      if (rd_en) rdPtr <= (rdPtr + 1'b1) & MASK;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ceespu_writeback.sv
// Writeback arbiter (ALU > queued load > bypassed load) into the single regfile port,
// plus the load scoreboard that stalls decode on RAW/WAW against in-flight loads.
module ceespu_writeback
  import ceespu_pkg::*;
#(
  parameter int DATA_W   = CEESPU_DATA_W,
  parameter int REG_AW   = CEESPU_REG_AW,
  parameter int LQ_DEPTH = 2
) (
  input logic               I_clk,
  input logic               I_rst,
  ceespu_writeback_if.slave bus
);
  localparam int NREGS = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

  wbEntry_t          qHead;
  wbEntry_t          ldIn;
  wbEntry_t          win;
  logic              qFull;
  logic              qEmpty;
  logic              ldAccept;
  logic              aluWin;
  logic              qWin;
  logic              bypWin;
  logic              loadWin;
  logic              decSet;
  logic              stall;
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busyNext;
  logic              weQ;
  logic [REG_AW-1:0] selDQ;
  logic [DATA_W-1:0] dataDQ;
  logic              errQ;

  assign ldAccept = bus.I_ld_valid & ~qFull;
  assign aluWin   = bus.I_alu_valid;
  assign qWin     = ~aluWin & ~qEmpty;
  // A load may skip the queue only when nothing older is waiting in it.
  assign bypWin   = ~aluWin & qEmpty & ldAccept;
  assign loadWin  = qWin | bypWin;
  assign ldIn     = '{rd: bus.I_ld_rd, data: bus.I_ld_data};

  ceespu_wb_fifo #(
    .WIDTH(REG_AW + DATA_W),
    .DEPTH(LQ_DEPTH)
  ) u_lq (
    .I_clk  (I_clk),
    .I_rst  (I_rst),
    .wr_en  (ldAccept & ~bypWin),
    .wrData (ldIn),
    .rd_en  (qWin),
    .full   (qFull),
    .empty  (qEmpty),
    .head   (qHead)
  );

  always_comb begin
    win = ldIn;
    if (aluWin) begin
      win = '{rd: bus.I_alu_rd, data: bus.I_alu_data};
    end else if (qWin) begin
      win = qHead;
    end
  end

  assign stall  = bus.I_dec_valid &
                  (busy[bus.I_selA] | busy[bus.I_selB] | (bus.I_dec_we & busy[bus.I_dec_rd]));
  assign decSet = bus.I_dec_valid & bus.I_dec_we & bus.I_dec_is_load & ~stall;

  // Set is applied after clear so a same-edge issue to the same register keeps it busy.
  always_comb begin
    busyNext = busy;
    if (loadWin) busyNext[win.rd] = 1'b0;
    if (decSet)  busyNext[bus.I_dec_rd] = 1'b1;
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      busy   <= '0;
      weQ    <= 1'b0;
      selDQ  <= '0;
      dataDQ <= '0;
      errQ   <= 1'b0;
    end else begin
      busy <= busyNext;
      weQ  <= aluWin | loadWin;
      if (aluWin | loadWin) begin
        selDQ  <= win.rd;
        dataDQ <= win.data;
      end
      if (ldAccept & ~busy[bus.I_ld_rd]) errQ <= 1'b1;
    end
  end

  assign bus.O_stall    = stall;
  assign bus.O_ld_ready = ~qFull;
  assign bus.O_we       = weQ;
  assign bus.O_selD     = selDQ;
  assign bus.O_dataD    = dataDQ;
  assign bus.O_err      = errQ;
endmodule

// File: tb/tb_ceespu_writeback.sv
// Bench for ceespu_writeback: directed scenarios plus a randomized run against a
// queue-based behavioural model of the writeback rules.
module tb_ceespu_writeback;
  localparam int LQ = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic I_clk;
  logic I_rst;
  int   checks;
  int   errors;

  bit [31:0]   mBusy;
  ent_t        mQ[$];
  logic        mWe;
  logic [4:0]  mSel;
  logic [31:0] mData;
  logic        mErr;

  ceespu_writeback_if bus ();

  ceespu_writeback #(.DATA_W(32), .REG_AW(5), .LQ_DEPTH(LQ)) dut (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .bus   (bus)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_stall();
    return bus.I_dec_valid && (mBusy[bus.I_selA] || mBusy[bus.I_selB] ||
                               (bus.I_dec_we && mBusy[bus.I_dec_rd]));
  endfunction

  function automatic bit m_ready();
    return mQ.size() < LQ;
  endfunction

  function automatic void m_reset();
    mBusy = '0;
    mQ.delete();
    mWe = 1'b0;
    mSel = '0;
    mData = '0;
    mErr = 1'b0;
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  function automatic void m_edge();
    bit   acc, st, used;
    ent_t e;
    st   = m_stall();
    acc  = bus.I_ld_valid && m_ready();
    used = 1'b0;
    if (acc && !mBusy[bus.I_ld_rd]) mErr = 1'b1;
    if (bus.I_alu_valid) begin
      mWe = 1'b1; mSel = bus.I_alu_rd; mData = bus.I_alu_data;
    end else if (mQ.size() > 0) begin
      e = mQ.pop_front();
      mWe = 1'b1; mSel = e.rd; mData = e.d;
      mBusy[e.rd] = 1'b0;
    end else if (acc) begin
      mWe = 1'b1; mSel = bus.I_ld_rd; mData = bus.I_ld_data;
      mBusy[bus.I_ld_rd] = 1'b0;
      used = 1'b1;
    end else begin
      mWe = 1'b0;
    end
    if (acc && !used) begin
      e.rd = bus.I_ld_rd;
      e.d  = bus.I_ld_data;
      mQ.push_back(e);
    end
    if (bus.I_dec_valid && bus.I_dec_we && bus.I_dec_is_load && !st) mBusy[bus.I_dec_rd] = 1'b1;
  endfunction

  task automatic tick();
    m_edge();
    @(posedge I_clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.I_dec_valid = 0; bus.I_dec_we = 0; bus.I_dec_is_load = 0;
    bus.I_dec_rd = '0; bus.I_selA = '0; bus.I_selB = '0;
    bus.I_alu_valid = 0; bus.I_alu_rd = '0; bus.I_alu_data = '0;
    bus.I_ld_valid = 0; bus.I_ld_rd = '0; bus.I_ld_data = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    I_rst = 1'b1;
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    m_reset();
  endtask

  task automatic issue_load(input logic [4:0] rd);
    drive_idle();
    bus.I_dec_valid = 1; bus.I_dec_we = 1; bus.I_dec_is_load = 1; bus.I_dec_rd = rd;
    bus.I_selA = 5'd31; bus.I_selB = 5'd31;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    bus.I_dec_valid = 1; bus.I_dec_we = 1; bus.I_selA = 5'd4; bus.I_selB = 5'd17; bus.I_dec_rd = 5'd9;
    #1;
    checks++;
    if (bus.O_we !== 1'b0 || bus.O_selD !== 5'd0 || bus.O_dataD !== 32'd0 || bus.O_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs we=%b sel=%0d data=%h err=%b expected all zero",
               bus.O_we, bus.O_selD, bus.O_dataD, bus.O_err);
    end
    checks++;
    if (bus.O_stall !== 1'b0 || bus.O_ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb stall=%b ready=%b expected 0 1", bus.O_stall, bus.O_ld_ready);
    end
    drive_idle();
  endtask

  task automatic test_alu();
    drive_idle();
    bus.I_alu_valid = 1; bus.I_alu_rd = 5'd3; bus.I_alu_data = 32'h1234;
    tick();
    checks++;
    if (bus.O_we !== 1'b1 || bus.O_selD !== 5'd3 || bus.O_dataD !== 32'h1234) begin
      errors++;
      $display("FAIL alu_write we=%b sel=%0d data=%h expected 1 3 00001234", bus.O_we, bus.O_selD, bus.O_dataD);
    end
    drive_idle();
    tick();
    checks++;
    if (bus.O_we !== 1'b0 || bus.O_selD !== 5'd3 || bus.O_dataD !== 32'h1234) begin
      errors++;
      $display("FAIL alu_idle we=%b sel=%0d data=%h expected 0 3 00001234 (hold)", bus.O_we, bus.O_selD, bus.O_dataD);
    end
  endtask

  task automatic test_load_stall();
    issue_load(5'd5);
    drive_idle();
    bus.I_dec_valid = 1; bus.I_selA = 5'd5; bus.I_selB = 5'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.O_stall !== 1'b1) begin
        errors++;
        $display("FAIL raw_stall cycle %0d stall=%b expected 1", i, bus.O_stall);
      end
      tick();
    end
    bus.I_ld_valid = 1; bus.I_ld_rd = 5'd5; bus.I_ld_data = 32'hDEAD;
    #1;
    checks++;
    if (bus.O_stall !== 1'b1 || bus.O_ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_stall_at_result stall=%b ready=%b expected 1 1", bus.O_stall, bus.O_ld_ready);
    end
    tick();
    bus.I_ld_valid = 0;
    #1;
    checks++;
    if (bus.O_we !== 1'b1 || bus.O_selD !== 5'd5 || bus.O_dataD !== 32'hDEAD || bus.O_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_write we=%b sel=%0d data=%h stall=%b expected 1 5 0000dead 0",
               bus.O_we, bus.O_selD, bus.O_dataD, bus.O_stall);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_queue();
    logic [4:0] expSel[6];
    logic       expWe[6];
    issue_load(5'd6);
    issue_load(5'd7);
    expSel = '{5'd10, 5'd11, 5'd12, 5'd6, 5'd7, 5'd7};
    expWe  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_idle();
      if (i < 3) begin
        bus.I_alu_valid = 1; bus.I_alu_rd = 5'(10 + i); bus.I_alu_data = 32'(i + 100);
      end
      if (i < 2) begin
        bus.I_ld_valid = 1; bus.I_ld_rd = 5'(6 + i); bus.I_ld_data = 32'hA000 + 32'(i);
      end
      #1;
      checks++;
      if (bus.O_ld_ready !== ((i == 2 || i == 3) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL queue_ready cycle %0d ready=%b queued=%0d", i, bus.O_ld_ready, mQ.size());
      end
      tick();
      checks++;
      if (bus.O_we !== expWe[i] || bus.O_selD !== expSel[i] || bus.O_dataD !== mData) begin
        errors++;
        $display("FAIL queue_order cycle %0d we=%b sel=%0d data=%h expected %b %0d %h",
                 i, bus.O_we, bus.O_selD, bus.O_dataD, expWe[i], expSel[i], mData);
      end
    end
  endtask

  task automatic test_err();
    drive_idle();
    bus.I_ld_valid = 1; bus.I_ld_rd = 5'd9; bus.I_ld_data = 32'h9999;
    #1;
    checks++;
    if (bus.O_err !== 1'b0) begin
      errors++;
      $display("FAIL err_before err=%b expected 0", bus.O_err);
    end
    tick();
    checks++;
    if (bus.O_we !== 1'b1 || bus.O_selD !== 5'd9 || bus.O_dataD !== 32'h9999 || bus.O_err !== 1'b1) begin
      errors++;
      $display("FAIL err_write we=%b sel=%0d data=%h err=%b expected 1 9 00009999 1",
               bus.O_we, bus.O_selD, bus.O_dataD, bus.O_err);
    end
    drive_idle();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.O_err !== 1'b1 || bus.O_we !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky err=%b we=%b expected 1 0", bus.O_err, bus.O_we);
    end
  endtask

  task automatic test_same_edge();
    drive_idle();
    bus.I_dec_valid = 1; bus.I_dec_we = 1; bus.I_dec_is_load = 1; bus.I_dec_rd = 5'd8;
    bus.I_selA = 5'd1; bus.I_selB = 5'd2;
    bus.I_ld_valid = 1; bus.I_ld_rd = 5'd8; bus.I_ld_data = 32'h88;
    #1;
    checks++;
    if (bus.O_stall !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_issue stall=%b expected 0", bus.O_stall);
    end
    tick();
    drive_idle();
    bus.I_dec_valid = 1; bus.I_dec_we = 1; bus.I_dec_rd = 5'd8; bus.I_selA = 5'd1; bus.I_selB = 5'd2;
    #1;
    checks++;
    if (bus.O_we !== 1'b1 || bus.O_selD !== 5'd8 || bus.O_stall !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_waw we=%b sel=%0d stall=%b expected 1 8 1", bus.O_we, bus.O_selD, bus.O_stall);
    end
    tick();
    bus.I_ld_valid = 1; bus.I_ld_rd = 5'd8; bus.I_ld_data = 32'h99;
    tick();
    bus.I_ld_valid = 0;
    #1;
    checks++;
    if (bus.O_we !== 1'b1 || bus.O_dataD !== 32'h99 || bus.O_stall !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_release we=%b data=%h stall=%b expected 1 00000099 0",
               bus.O_we, bus.O_dataD, bus.O_stall);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    int cand[$];
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.I_dec_valid   = 1'($urandom_range(0, 1));
      bus.I_dec_we      = ($urandom % 4) != 0;
      bus.I_dec_is_load = 1'($urandom_range(0, 1));
      bus.I_dec_rd      = 5'($urandom_range(0, 7));
      bus.I_selA        = 5'($urandom_range(0, 11));
      bus.I_selB        = 5'($urandom_range(0, 11));
      bus.I_alu_valid   = ($urandom % 10) < 3;
      bus.I_alu_rd      = 5'($urandom_range(0, 31));
      bus.I_alu_data    = $urandom;
      bus.I_ld_valid    = ($urandom % 10) < 4;
      bus.I_ld_data     = $urandom;
      cand.delete();
      for (int r = 0; r < 32; r++) if (mBusy[r]) cand.push_back(r);
      if (cand.size() > 0 && ($urandom % 8) != 0)
        bus.I_ld_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        bus.I_ld_rd = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (bus.O_stall !== m_stall() || bus.O_ld_ready !== m_ready()) begin
        errors++;
        $display("FAIL rand_comb cycle %0d stall=%b ready=%b expected %b %b",
                 i, bus.O_stall, bus.O_ld_ready, m_stall(), m_ready());
      end
      tick();
      checks++;
      if (bus.O_we !== mWe || bus.O_selD !== mSel || bus.O_dataD !== mData || bus.O_err !== mErr) begin
        errors++;
        $display("FAIL rand_write cycle %0d we=%b sel=%0d data=%h err=%b expected %b %0d %h %b",
                 i, bus.O_we, bus.O_selD, bus.O_dataD, bus.O_err, mWe, mSel, mData, mErr);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.I_ld_valid = 1; bus.I_ld_rd = 5'd30; bus.I_ld_data = 32'h3030;
    tick();
    issue_load(5'd20);
    issue_load(5'd21);
    for (int i = 0; i < 2; i++) begin
      drive_idle();
      bus.I_alu_valid = 1; bus.I_alu_rd = 5'd1; bus.I_alu_data = 32'h55;
      bus.I_ld_valid = 1; bus.I_ld_rd = 5'(20 + i); bus.I_ld_data = 32'hB000 + 32'(i);
      tick();
    end
    drive_idle();
    bus.I_alu_valid = 1; bus.I_alu_rd = 5'd2; bus.I_alu_data = 32'h66;
    bus.I_dec_valid = 1; bus.I_selA = 5'd20; bus.I_selB = 5'd0;
    #1;
    checks++;
    if (bus.O_stall !== 1'b1 || bus.O_ld_ready !== 1'b0 || bus.O_err !== 1'b1 || bus.O_we !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset stall=%b ready=%b err=%b we=%b expected 1 0 1 1",
               bus.O_stall, bus.O_ld_ready, bus.O_err, bus.O_we);
    end
    #1;
    I_rst = 1'b1;
    #1;
    checks++;
    if (bus.O_we !== 1'b0 || bus.O_selD !== 5'd0 || bus.O_dataD !== 32'd0 || bus.O_err !== 1'b0 ||
        bus.O_stall !== 1'b0 || bus.O_ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset we=%b sel=%0d data=%h err=%b stall=%b ready=%b expected 0 0 0 0 0 1",
               bus.O_we, bus.O_selD, bus.O_dataD, bus.O_err, bus.O_stall, bus.O_ld_ready);
    end
    bus.I_alu_valid = 0;
    @(negedge I_clk);
    I_rst = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.O_we !== 1'b0 || bus.O_stall !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cycle %0d we=%b stall=%b expected 0 0", i, bus.O_we, bus.O_stall);
      end
    end
    drive_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    I_rst  = 1'b1;
    drive_idle();
    m_reset();
    #1;
    test_reset();
    test_alu();
    test_load_stall();
    test_queue();
    test_err();
    test_same_edge();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
